// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drac_pkg
//  Description : Shared types and constants for the core-to-PCR-bus bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package drac_pkg;

  localparam int PCR_ADDR_W = 12;
  localparam int PCR_CMD_W  = 3;
  localparam int PCR_DATA_W = 64;
  localparam int CORE_ID_W  = 64;

  // One captured core request, as it is presented on the bus
  typedef struct packed {
    logic [PCR_ADDR_W-1:0] addr;
    logic [PCR_DATA_W-1:0] data;
    logic [PCR_CMD_W-1:0]  we;
    logic [CORE_ID_W-1:0]  core_id;
  } pcr_req_t;

  // One response as returned to the core
  typedef struct packed {
    logic [PCR_DATA_W-1:0] data;
    logic [CORE_ID_W-1:0]  core_id;
    logic                  err;
  } pcr_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESP      = 2'd3
  } pcr_bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/pcr_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pcr_timeout_timer
//  Description : Response watchdog. Counts enabled cycles from zero and flags
//                the cycle in which the count reaches TIMEOUT_CYCLES-1.
//                TIMEOUT_CYCLES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcr_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Cycle counter; clear has priority over enable
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired_o = enable_i && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/drac_pcr_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : drac_pcr_bridge
//  Description : Single-outstanding bridge from the core PCR request port to
//                the shared tile PCR bus. Filters broadcast responses by core
//                ID, counts unexpected responses, and synthesizes an error
//                response if the bus never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module drac_pcr_bridge
  import drac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [63:0]           core_id_i,

  input  logic                  core_req_valid_i,
  output logic                  core_req_ready_o,
  input  logic [11:0]           core_req_addr_i,
  input  logic [63:0]           core_req_data_i,
  input  logic [2:0]            core_req_we_i,

  output logic                  core_resp_valid_o,
  output logic [63:0]           core_resp_data_o,
  output logic [63:0]           core_resp_core_id_o,
  output logic                  core_resp_err_o,

  output logic                  bus_req_valid_o,
  input  logic                  bus_req_ready_i,
  output logic [11:0]           bus_req_addr_o,
  output logic [63:0]           bus_req_data_o,
  output logic [2:0]            bus_req_we_o,
  output logic [63:0]           bus_req_core_id_o,

  input  logic                  bus_resp_valid_i,
  input  logic [63:0]           bus_resp_data_i,
  input  logic [63:0]           bus_resp_core_id_i,

  output logic                  busy_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  pcr_bridge_state_t     r_state;
  pcr_req_t              r_req;
  pcr_resp_t             r_resp;
  logic                  r_bus_req_valid;
  logic                  r_core_resp_valid;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic w_in_wait;
  logic w_resp_match;
  logic w_resp_drop;
  logic w_expired;

  // Only a response addressed to the captured ID while waiting is ours;
  // anything else seen on the broadcast bus is counted as dropped.
  assign w_in_wait    = (r_state == ST_WAIT_RESP);
  assign w_resp_match = bus_resp_valid_i && w_in_wait &&
                        (bus_resp_core_id_i == r_req.core_id);
  assign w_resp_drop  = bus_resp_valid_i && !w_resp_match;

  // Timer is held at zero outside WAIT_RESP, so it starts from 0 on the
  // first waiting cycle after the bus handshake.
  pcr_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (!w_in_wait),
    .enable_i  (w_in_wait),
    .expired_o (w_expired)
  );

  // Transaction FSM with registered request/response payloads
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state           <= ST_IDLE;
      r_req             <= '0;
      r_resp            <= '0;
      r_bus_req_valid   <= 1'b0;
      r_core_resp_valid <= 1'b0;
    end else begin
      r_core_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (core_req_valid_i) begin
            r_req <= '{addr:    core_req_addr_i,
                       data:    core_req_data_i,
                       we:      core_req_we_i,
                       core_id: core_id_i};
            r_bus_req_valid <= 1'b1;
            r_state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_req_ready_i) begin
            r_bus_req_valid <= 1'b0;
            r_state         <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          // A match in the expiry cycle still returns the real bus data
          if (w_resp_match) begin
            r_resp <= '{data:    bus_resp_data_i,
                        core_id: bus_resp_core_id_i,
                        err:     1'b0};
            r_core_resp_valid <= 1'b1;
            r_state           <= ST_RESP;
          end else if (w_expired) begin
            r_resp <= '{data:    64'd0,
                        core_id: r_req.core_id,
                        err:     1'b1};
            r_core_resp_valid <= 1'b1;
            r_state           <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of responses that were not for the pending request
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_drop_cnt <= '0;
    end else if (w_resp_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign core_req_ready_o    = (r_state == ST_IDLE);
  assign busy_o              = (r_state != ST_IDLE);

  assign core_resp_valid_o   = r_core_resp_valid;
  assign core_resp_data_o    = r_resp.data;
  assign core_resp_core_id_o = r_resp.core_id;
  assign core_resp_err_o     = r_resp.err;

  assign bus_req_valid_o     = r_bus_req_valid;
  assign bus_req_addr_o      = r_req.addr;
  assign bus_req_data_o      = r_req.data;
  assign bus_req_we_o        = r_req.we;
  assign bus_req_core_id_o   = r_req.core_id;

  assign drop_cnt_o          = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_drac_pcr_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_drac_pcr_bridge
//  Description : Self-checking bench for drac_pcr_bridge with a transaction
//                level reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drac_pcr_bridge;

  localparam int T  = 8;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [63:0]   core_id;
  logic          core_req_valid;
  logic          core_req_ready;
  logic [11:0]   core_req_addr;
  logic [63:0]   core_req_data;
  logic [2:0]    core_req_we;
  logic          core_resp_valid;
  logic [63:0]   core_resp_data;
  logic [63:0]   core_resp_core_id;
  logic          core_resp_err;
  logic          bus_req_valid;
  logic          bus_req_ready;
  logic [11:0]   bus_req_addr;
  logic [63:0]   bus_req_data;
  logic [2:0]    bus_req_we;
  logic [63:0]   bus_req_core_id;
  logic          bus_resp_valid;
  logic [63:0]   bus_resp_data;
  logic [63:0]   bus_resp_core_id;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  always #5 clk = ~clk;

  drac_pcr_bridge #(.TIMEOUT_CYCLES(T), .DROP_CNT_W(DW)) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .core_id_i           (core_id),
    .core_req_valid_i    (core_req_valid),
    .core_req_ready_o    (core_req_ready),
    .core_req_addr_i     (core_req_addr),
    .core_req_data_i     (core_req_data),
    .core_req_we_i       (core_req_we),
    .core_resp_valid_o   (core_resp_valid),
    .core_resp_data_o    (core_resp_data),
    .core_resp_core_id_o (core_resp_core_id),
    .core_resp_err_o     (core_resp_err),
    .bus_req_valid_o     (bus_req_valid),
    .bus_req_ready_i     (bus_req_ready),
    .bus_req_addr_o      (bus_req_addr),
    .bus_req_data_o      (bus_req_data),
    .bus_req_we_o        (bus_req_we),
    .bus_req_core_id_o   (bus_req_core_id),
    .bus_resp_valid_i    (bus_resp_valid),
    .bus_resp_data_i     (bus_resp_data),
    .bus_resp_core_id_i  (bus_resp_core_id),
    .busy_o              (busy),
    .drop_cnt_o          (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_have: a request is held by the bridge; m_acc: the bus has taken it;
  // m_waited: cycles spent waiting since the bus took it; m_inresp: the
  // response is being shown to the core this cycle.
  logic        m_started = 1'b0;
  logic        m_have, m_acc, m_inresp;
  int          m_waited;
  int          m_drops;
  logic [11:0] m_addr;
  logic [63:0] m_data, m_id, m_rdata, m_rid;
  logic [2:0]  m_we;
  logic        m_rerr;

  always @(posedge clk) begin : model
    logic hit;
    hit = 1'b0;
    m_started = 1'b1;
    if (!rstn) begin
      m_have = 0; m_acc = 0; m_inresp = 0; m_waited = 0; m_drops = 0;
      m_addr = '0; m_data = '0; m_we = '0; m_id = '0;
      m_rdata = '0; m_rid = '0; m_rerr = 0;
    end else begin
      if (bus_resp_valid) begin
        if (m_have && m_acc && bus_resp_core_id == m_id) hit = 1'b1;
        else if (m_drops < (1 << DW) - 1) m_drops++;
      end
      if (m_inresp) begin
        m_inresp = 0;
      end else if (!m_have) begin
        if (core_req_valid) begin
          m_have = 1; m_acc = 0;
          m_addr = core_req_addr; m_data = core_req_data;
          m_we = core_req_we; m_id = core_id;
        end
      end else if (!m_acc) begin
        if (bus_req_ready) begin
          m_acc = 1; m_waited = 0;
        end
      end else begin
        m_waited++;
        if (hit) begin
          m_rdata = bus_resp_data; m_rid = bus_resp_core_id; m_rerr = 0;
          m_have = 0; m_inresp = 1;
        end else if (m_waited == T) begin
          m_rdata = '0; m_rid = m_id; m_rerr = 1;
          m_have = 0; m_inresp = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare and event monitors ----------------
  int hs_cnt    = 0;
  int pulse_cnt = 0;

  always @(negedge clk) begin
    if (m_started) begin
      chk("ready",       core_req_ready,    !m_have && !m_inresp);
      chk("busy",        busy,              m_have || m_inresp);
      chk("bus_valid",   bus_req_valid,     m_have && !m_acc);
      chk("bus_addr",    bus_req_addr,      m_addr);
      chk("bus_data",    bus_req_data,      m_data);
      chk("bus_we",      bus_req_we,        m_we);
      chk("bus_id",      bus_req_core_id,   m_id);
      chk("resp_valid",  core_resp_valid,   m_inresp);
      chk("resp_data",   core_resp_data,    m_rdata);
      chk("resp_id",     core_resp_core_id, m_rid);
      chk("resp_err",    core_resp_err,     m_rerr);
      chk("drop_cnt",    drop_cnt,          m_drops);
      if (bus_req_valid && bus_req_ready) hs_cnt++;
      if (core_resp_valid) pulse_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 0;
    core_req_valid = 0; bus_req_ready = 0; bus_resp_valid = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  // Present one request for one cycle; returns in the first REQ cycle
  task automatic send_req(input logic [11:0] a, input logic [63:0] d, input logic [2:0] w);
    core_req_valid = 1; core_req_addr = a; core_req_data = d; core_req_we = w;
    tick();
    core_req_valid = 0;
  endtask

  task automatic bus_resp(input logic [63:0] id, input logic [63:0] d);
    bus_resp_valid = 1; bus_resp_core_id = id; bus_resp_data = d;
    tick();
    bus_resp_valid = 0;
  endtask

  int base_hs, base_pulse;

  initial begin
    core_id = 64'd5; core_req_addr = '0; core_req_data = '0; core_req_we = '0;
    bus_resp_data = '0; bus_resp_core_id = '0;
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_ready", core_req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus_valid", bus_req_valid, 0);
    chk("rst_drop", drop_cnt, 0);

    // Read with an immediately ready bus
    tick();
    bus_req_ready = 1;
    send_req(12'hC03, 64'd0, 3'd0);                          // cycle 1
    @(negedge clk);
    chk("t1_bus_valid_c1", bus_req_valid, 1);
    chk("t1_bus_addr", bus_req_addr, 64'hC03);
    tick();                                                  // cycle 2
    tick();                                                  // cycle 3
    bus_resp(64'd5, 64'hDEAD);                               // cycle 4
    @(negedge clk);
    chk("t1_resp_valid_c4", core_resp_valid, 1);
    chk("t1_resp_data", core_resp_data, 64'hDEAD);
    chk("t1_resp_err", core_resp_err, 0);
    tick();                                                  // cycle 5
    @(negedge clk);
    chk("t1_ready_c5", core_req_ready, 1);

    // Backpressure for 7 cycles
    tick();
    bus_req_ready = 0;
    base_hs = hs_cnt;
    send_req(12'h123, 64'hA5A5_0000_1111_2222, 3'd3);
    repeat (7) begin
      @(negedge clk);
      chk("t2_bus_valid", bus_req_valid, 1);
      chk("t2_bus_addr", bus_req_addr, 64'h123);
      chk("t2_bus_data", bus_req_data, 64'hA5A5_0000_1111_2222);
      chk("t2_ready", core_req_ready, 0);
      tick();
    end
    bus_req_ready = 1;
    tick();
    bus_req_ready = 0;
    bus_resp(64'd5, 64'h77);
    @(negedge clk);
    chk("t2_resp_data", core_resp_data, 64'h77);
    tick();
    chk("t2_handshakes", hs_cnt - base_hs, 1);

    // Foreign responses while waiting
    do_reset();
    bus_req_ready = 1;
    base_pulse = pulse_cnt;
    send_req(12'h010, 64'h1, 3'd1);
    tick();
    bus_resp(64'd3, 64'h333);
    bus_resp(64'd9, 64'h999);
    bus_resp(64'd5, 64'h555);
    @(negedge clk);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_resp_data", core_resp_data, 64'h555);
    tick();
    tick();
    chk("t3_pulses", pulse_cnt - base_pulse, 1);

    // Timeout with no response, different core ID
    core_id = 64'hCAFE_0000_0000_0042;
    send_req(12'h020, 64'h2, 3'd2);
    tick();                                                  // WAIT entry E
    repeat (7) tick();                                       // E+7
    @(negedge clk);
    chk("t4_no_resp_e7", core_resp_valid, 0);
    tick();                                                  // E+8
    @(negedge clk);
    chk("t4_to_valid", core_resp_valid, 1);
    chk("t4_to_data", core_resp_data, 0);
    chk("t4_to_err", core_resp_err, 1);
    chk("t4_to_id", core_resp_core_id, 64'hCAFE_0000_0000_0042);
    tick();

    // Match on the final waiting cycle wins over expiry
    send_req(12'h021, 64'h3, 3'd0);
    tick();                                                  // E
    repeat (7) tick();                                       // E+7
    bus_resp(64'hCAFE_0000_0000_0042, 64'h1234);             // E+8
    @(negedge clk);
    chk("t4_late_valid", core_resp_valid, 1);
    chk("t4_late_err", core_resp_err, 0);
    chk("t4_late_data", core_resp_data, 64'h1234);
    tick();
    core_id = 64'd5;

    // Stray responses and saturation
    do_reset();
    bus_resp(64'd5, 64'hAB);
    @(negedge clk);
    chk("t5_stray1", drop_cnt, 1);
    repeat (4) bus_resp(64'd7, 64'hCD);
    @(negedge clk);
    chk("t5_saturated", drop_cnt, 3);

    // Reset during WAIT_RESP abandons the transaction silently
    bus_req_ready = 1;
    send_req(12'h030, 64'h4, 3'd4);
    tick();
    tick();
    rstn = 0;
    tick();
    rstn = 1;
    base_pulse = pulse_cnt;
    @(negedge clk);
    chk("t6_ready", core_req_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_bus_valid", bus_req_valid, 0);
    chk("t6_bus_addr", bus_req_addr, 0);
    chk("t6_resp_valid", core_resp_valid, 0);
    chk("t6_resp_data", core_resp_data, 0);
    chk("t6_drop", drop_cnt, 0);
    repeat (12) tick();
    chk("t6_no_pulse", pulse_cnt - base_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
